// File: rtl/dbg_sba_pkg.sv
// Shared types for the scripted system-bus initiator: FSM states, the buffered
// command and the registered response.
package dbg_sba_pkg;

    localparam int SBA_ADDR_W = 32;
    localparam int SBA_DATA_W = 32;
    localparam int SBA_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } sba_state_e;

    typedef struct packed {
        logic                  we;
        logic [SBA_BE_W-1:0]   be;
        logic [SBA_ADDR_W-1:0] addr;
        logic [SBA_DATA_W-1:0] wdata;
    } sba_cmd_t;

    typedef struct packed {
        logic [SBA_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } sba_rsp_t;

endpackage

// File: rtl/dbg_sba_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that full and
// empty fall straight out of a pointer compare.
module dbg_sba_cmd_fifo
    import dbg_sba_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     IO_CLK,
    input  logic     IO_RST_N,
    input  logic     i_push,
    input  sba_cmd_t i_wdata,
    input  logic     i_pop,
    output sba_cmd_t o_rdata,
    output logic     o_full,
    output logic     o_empty
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0] r_wptr;
    logic [PtrW:0] r_rptr;
    sba_cmd_t      r_mem [Depth];

    // NOTE: storage is deliberately left out of reset; only the pointers decide
    // which entries are valid, so resetting the array would buy nothing.
    always_ff @(posedge IO_CLK) begin
        if (i_push && !o_full) begin
            r_mem[r_wptr[PtrW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (i_pop && !o_empty) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[PtrW] != r_rptr[PtrW]) &&
                     (r_wptr[PtrW-1:0] == r_rptr[PtrW-1:0]);
    assign o_rdata = r_mem[r_rptr[PtrW-1:0]];

endmodule

// File: rtl/dbg_sba_initiator.sv
// Scripted bus initiator: buffers read/write commands, issues them one at a time
// on a req/gnt/rvalid host port and returns one in-order response per command.
module dbg_sba_initiator
    import dbg_sba_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned CmdDepth      = 2,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 IO_CLK,
    input  logic                 IO_RST_N,

    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [3:0]           cmd_be_i,
    input  logic [DataWidth-1:0] cmd_wdata_i,

    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,

    output logic                 host_req_o,
    output logic                 host_we_o,
    output logic [3:0]           host_be_o,
    output logic [AddrWidth-1:0] host_addr_o,
    output logic [DataWidth-1:0] host_wdata_o,
    input  logic                 host_gnt_i,
    input  logic                 host_rvalid_i,
    input  logic                 host_err_i,
    input  logic [DataWidth-1:0] host_rdata_i,

    output logic                 busy_o,
    output logic                 hung_o
);

    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    if (DataWidth != SBA_DATA_W || AddrWidth > SBA_ADDR_W || CmdDepth < 2 ||
        (CmdDepth & (CmdDepth - 1)) != 0 || TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_bad_param
        $error("dbg_sba_initiator: unsupported parameter combination");
    end

    sba_state_e      r_state;
    sba_cmd_t        r_txn;
    sba_rsp_t        r_rsp;
    logic [CntW-1:0] r_cnt;
    logic            r_hung;

    sba_cmd_t w_cmd_in;
    sba_cmd_t w_fifo_head;
    sba_cmd_t w_head;
    logic     w_full;
    logic     w_empty;
    logic     w_fire;
    logic     w_idle;
    logic     w_bypass;
    logic     w_push;
    logic     w_pop;
    logic     w_take;
    logic     w_cnt_hit;

    assign w_cmd_in = '{
        we:    cmd_we_i,
        be:    cmd_be_i,
        addr:  SBA_ADDR_W'(cmd_addr_i),
        wdata: SBA_DATA_W'(cmd_wdata_i)
    };

    // An idle FSM with an empty FIFO takes the incoming command directly, so a
    // command accepted in one cycle is on the bus in the next.
    assign w_fire   = cmd_valid_i && !w_full;
    assign w_idle   = (r_state == IDLE);
    assign w_bypass = w_idle && w_empty && w_fire;
    assign w_push   = w_fire && !w_bypass;
    assign w_pop    = w_idle && !w_empty;
    assign w_take   = w_pop || w_bypass;
    assign w_head   = w_empty ? w_cmd_in : w_fifo_head;

    dbg_sba_cmd_fifo #(
        .Depth (CmdDepth)
    ) u_cmd_fifo (
        .IO_CLK   (IO_CLK),
        .IO_RST_N (IO_RST_N),
        .i_push   (w_push),
        .i_wdata  (w_cmd_in),
        .i_pop    (w_pop),
        .o_rdata  (w_fifo_head),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // The counter starts at zero in the first WAIT cycle, so hitting T-1 there
    // means TimeoutCycles cycles have elapsed without rvalid.
    assign w_cnt_hit = (r_cnt == CntW'(TimeoutCycles - 1));

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            r_state <= IDLE;
            r_txn   <= '0;
            r_rsp   <= '0;
            r_cnt   <= '0;
            r_hung  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_txn <= w_head;
                        if (r_hung) begin
                            r_rsp.rdata   <= '0;
                            r_rsp.err     <= 1'b1;
                            r_rsp.timeout <= 1'b1;
                            r_state       <= RSP;
                        end else begin
                            r_state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (host_gnt_i) begin
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (host_rvalid_i) begin
                        r_rsp.rdata   <= (!r_txn.we && !host_err_i) ? SBA_DATA_W'(host_rdata_i) : '0;
                        r_rsp.err     <= host_err_i;
                        r_rsp.timeout <= 1'b0;
                        r_state       <= RSP;
                    end else if (w_cnt_hit) begin
                        r_rsp.rdata   <= '0;
                        r_rsp.err     <= 1'b1;
                        r_rsp.timeout <= 1'b1;
                        r_hung        <= 1'b1;
                        r_state       <= RSP;
                    end else if (r_cnt != CntW'(TimeoutCycles)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = !w_full;

    assign rsp_valid_o   = (r_state == RSP);
    assign rsp_rdata_o   = r_rsp.rdata[DataWidth-1:0];
    assign rsp_err_o     = r_rsp.err;
    assign rsp_timeout_o = r_rsp.timeout;

    assign host_req_o    = (r_state == REQ);
    assign host_we_o     = r_txn.we;
    assign host_be_o     = r_txn.be;
    assign host_addr_o   = r_txn.addr[AddrWidth-1:0];
    assign host_wdata_o  = r_txn.wdata[DataWidth-1:0];

    assign busy_o        = !w_empty || !w_idle;
    assign hung_o        = r_hung;

endmodule
